// File: rtl/mul_share_arbiter_if.sv
// Request/response bundle between clients and the shared 8x8 multiplier.
// The slave modport is the arbiter side; the master modport is the client side.
interface mul_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_a;
    logic [8*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 resp_valid;
    logic [15:0]          resp_mul;
    logic [ID_W-1:0]      resp_id;
    logic                 resp_ready;
    logic                 busy;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_mul, resp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_mul, resp_id, busy
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one combinational 8x8 array multiplier among
// NUM_REQ requesters; operands and result are registered, one job in flight.
module mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    mul_share_arbiter_if.slave  bus
);
    localparam int unsigned N = NUM_REQ;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [7:0]      op_a_q, op_a_d;
    logic [7:0]      op_b_q, op_b_d;
    logic [15:0]     mul_q, mul_d;

    logic            found;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] cand;
    logic [7:0]      win_a, win_b;
    logic [15:0]     mul_w;

    // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = ID_W'((rr_ptr_q + k) % N);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (winner == ID_W'(k)) begin
                win_a = bus.req_a[8*k +: 8];
                win_b = bus.req_b[8*k +: 8];
            end
        end
    end

    // Array multiplier: sum of shifted partial products, fed only from op regs.
    always_comb begin
        mul_w = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (op_b_q[i]) begin
                mul_w = mul_w + ({8'b0, op_a_q} << i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            mul_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            mul_q    <= mul_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        mul_d    = mul_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    op_a_d   = win_a;
                    op_b_d   = win_b;
                    id_d     = winner;
                    rr_ptr_d = (winner == ID_W'(N - 1)) ? '0 : winner + 1'b1;
                    state_d  = MUL;
                end
            end
            MUL: begin
                mul_d   = mul_w;
                state_d = DONE;
            end
            DONE: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant is masked during reset so no requester sees its operands taken.
    always_comb begin
        bus.req_ready = '0;
        if (state_q == IDLE && found && !rst) begin
            bus.req_ready = NUM_REQ'(1) << winner;
        end
        bus.resp_valid = (state_q == DONE);
        bus.busy       = (state_q != IDLE);
        bus.resp_mul   = mul_q;
        bus.resp_id    = id_q;
    end
endmodule
